// File: rtl/router_output_ctrl.sv
// Per-output-port wormhole scheduler: round-robin head arbitration, packet lock, downstream credits.
// Optional stall detector enabled with `define ROUTER_OUTPUT_CTRL_STALL_DET_EN.
module router_output_ctrl #(
  parameter int NUM_IN      = 4,
  parameter int CREDITS     = 4,
  parameter int STALL_LIMIT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_IN-1:0]             in_valid,
  input  logic [NUM_IN-1:0]             in_head,
  input  logic [NUM_IN-1:0]             in_tail,
  input  logic                          credit_in,
  output logic [NUM_IN-1:0]             in_ready,
  output logic [NUM_IN-1:0]             out_sel,
  output logic                          out_valid,
  output logic [$clog2(CREDITS+1)-1:0]  credits,
  output logic                          locked,
  output logic                          stall_err
);
  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int CW = $clog2(CREDITS + 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_owner;
  logic [CW-1:0]   r_credits;

  logic [NUM_IN-1:0] w_cand;
  logic [NUM_IN-1:0] w_grant;
  logic [IW-1:0]     w_idx;
  logic [IW-1:0]     w_win;
  logic              w_found;
  logic              w_fire;
  logic              w_tail;

  // Handshake: a flit on input i moves exactly in the cycle in_ready[i] is high;
  // in_ready is only ever raised where in_valid is already high, and never without a credit.
  always_comb begin
    w_cand  = in_valid & in_head;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % NUM_IN);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    w_grant = '0;
    if (r_credits != '0) begin
      if (r_state == ST_IDLE) begin
        if (w_found) w_grant[w_win] = 1'b1;
      end else if (in_valid[r_owner]) begin
        w_grant[r_owner] = 1'b1;
      end
    end
    w_fire = |w_grant;
    w_tail = |(w_grant & in_tail);
  end

  assign in_ready  = w_grant;
  assign out_sel   = w_grant;
  assign out_valid = w_fire;
  assign credits   = r_credits;
  assign locked    = (r_state == ST_LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= IW'(NUM_IN - 1);
      r_owner   <= '0;
      r_credits <= CW'(CREDITS);
    end else begin
      // Credits saturate at full; a returned credit is only usable next cycle.
      if (w_fire && !credit_in)
        r_credits <= r_credits - CW'(1);
      else if (!w_fire && credit_in && r_credits != CW'(CREDITS))
        r_credits <= r_credits + CW'(1);

      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            if (w_tail) begin
              r_ptr <= w_win;
            end else begin
              r_state <= ST_LOCKED;
              r_owner <= w_win;
            end
          end
        end
        ST_LOCKED: begin
          if (w_fire && w_tail) begin
            r_state <= ST_IDLE;
            r_ptr   <= r_owner;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ROUTER_OUTPUT_CTRL_STALL_DET_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);

  logic [SW-1:0] r_stall_cnt;
  logic          r_stall_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else if (r_state == ST_LOCKED && !w_fire) begin
      if (r_stall_cnt != SW'(STALL_LIMIT)) r_stall_cnt <= r_stall_cnt + SW'(1);
      if (r_stall_cnt == SW'(STALL_LIMIT - 1)) r_stall_err <= 1'b1;
    end else begin
      r_stall_cnt <= '0;
    end
  end

  assign stall_err = r_stall_err;
`else
  assign stall_err = 1'b0;
`endif

`ifndef SYNTHESIS
  a_cfg: assert property (@(posedge clk) (CREDITS >= 1) && (STALL_LIMIT >= 1) && (NUM_IN >= 1));
  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
  a_ready_valid: assert property (@(posedge clk) disable iff (rst) (in_ready & ~in_valid) == '0);
  a_credit_ovf: assert property (@(posedge clk) disable iff (rst)
    !(credit_in && !w_fire && r_credits == CW'(CREDITS)));
  a_idle_body: assert property (@(posedge clk) disable iff (rst)
    !(r_state == ST_IDLE && |(in_valid & ~in_head)));
  a_locked_head: assert property (@(posedge clk) disable iff (rst)
    !(r_state == ST_LOCKED && in_valid[r_owner] && in_head[r_owner]));
`endif
endmodule

// File: tb/tb_router_output_ctrl.sv
// Self-checking bench for router_output_ctrl: arbitration order, wormhole lock, credits, reset, stall flag.
module tb_router_output_ctrl;
  localparam int N  = 4;
  localparam int CR = 4;
  localparam int SL = 8;
`ifdef ROUTER_OUTPUT_CTRL_STALL_DET_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_valid, in_head, in_tail;
  logic         credit_in;
  logic [N-1:0] in_ready, out_sel;
  logic         out_valid;
  logic [2:0]   credits;
  logic         locked;
  logic         stall_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [N-1:0] exp_q[$];

  router_output_ctrl #(.NUM_IN(N), .CREDITS(CR), .STALL_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_head(in_head), .in_tail(in_tail),
    .credit_in(credit_in), .in_ready(in_ready), .out_sel(out_sel), .out_valid(out_valid),
    .credits(credits), .locked(locked), .stall_err(stall_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic set_in(input logic [N-1:0] v, input logic [N-1:0] h,
                        input logic [N-1:0] t, input logic c);
    in_valid  = v;
    in_head   = h;
    in_tail   = t;
    credit_in = c;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in('0, '0, '0, 1'b0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in('0, '0, '0, 1'b0);
    next_cycle();
    next_cycle();
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
    n_tests++; if (credits !== 3'd4) begin n_fail++; $display("FAIL reset_credits: got %0d expected 4", credits); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (out_sel !== 4'b0000) begin n_fail++; $display("FAIL reset_out_sel: got %b expected 0000", out_sel); end
    n_tests++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
    n_tests++; if (stall_err !== 1'b0) begin n_fail++; $display("FAIL reset_stall_err: got %b expected 0", stall_err); end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(4'b0001 << (i % 4));
      set_in(4'hF, 4'hF, 4'hF, 1'b1);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (out_sel !== e || in_ready !== e || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got sel=%b ready=%b valid=%b expected %b", i, out_sel, in_ready, out_valid, e);
      end
      n_tests++;
      if (credits !== 3'd4) begin n_fail++; $display("FAIL rr_credits[%0d]: got %0d expected 4", i, credits); end
      next_cycle();
    end
    set_in('0, '0, '0, 1'b0);
  endtask

  task automatic test_wormhole();
    logic [N-1:0] tv [6] = '{4'b0010, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0010};
    logic [N-1:0] th [6] = '{4'b0010, 4'b0110, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
    logic [N-1:0] tt [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0110, 4'b0010};
    logic [N-1:0] es [6] = '{4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0010};
    logic         el [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [N-1:0] e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(es[i]);
      set_in(tv[i], th[i], tt[i], 1'b1);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (out_sel !== e || in_ready !== e) begin
        n_fail++;
        $display("FAIL worm_sel[%0d]: got sel=%b ready=%b expected %b", i, out_sel, in_ready, e);
      end
      n_tests++;
      if (locked !== el[i]) begin n_fail++; $display("FAIL worm_locked[%0d]: got %b expected %b", i, locked, el[i]); end
      next_cycle();
    end
    set_in('0, '0, '0, 1'b0);
  endtask

  task automatic test_credits();
    int mc, f;
    logic c, fire;
    logic [N-1:0] e;
    do_reset();
    mc = CR;
    f  = 0;
    for (int i = 0; i < 9; i++) begin
      c    = (i == 5) || (i == 7);
      fire = (mc != 0);
      exp_q.push_back(fire ? 4'b0001 : 4'b0000);
      set_in(4'b0001, (f == 0) ? 4'b0001 : 4'b0000, (f == 5) ? 4'b0001 : 4'b0000, c);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (out_sel !== e || out_valid !== fire) begin
        n_fail++;
        $display("FAIL cred_sel[%0d]: got sel=%b valid=%b expected %b", i, out_sel, out_valid, e);
      end
      n_tests++;
      if (credits !== 3'(mc)) begin n_fail++; $display("FAIL cred_count[%0d]: got %0d expected %0d", i, credits, mc); end
      n_tests++;
      if (locked !== (f > 0 && f < 6)) begin
        n_fail++;
        $display("FAIL cred_locked[%0d]: got %b expected %b", i, locked, (f > 0 && f < 6));
      end
      mc = mc - int'(fire) + int'(c);
      f  = f + int'(fire);
      next_cycle();
    end
    set_in('0, '0, '0, 1'b0);
    #1;
    n_tests++;
    if (locked !== 1'b0 || credits !== 3'd0) begin
      n_fail++;
      $display("FAIL cred_end: got locked=%b credits=%0d expected locked=0 credits=0", locked, credits);
    end
  endtask

  task automatic test_credit_simul();
    logic [N-1:0] tv [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int           ec [5] = '{4, 3, 2, 2, 3};
    logic [N-1:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(tv[i]);
      set_in(tv[i], tv[i], tv[i], tc[i]);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (out_sel !== e) begin n_fail++; $display("FAIL simul_sel[%0d]: got %b expected %b", i, out_sel, e); end
      n_tests++;
      if (credits !== 3'(ec[i])) begin n_fail++; $display("FAIL simul_credits[%0d]: got %0d expected %0d", i, credits, ec[i]); end
      next_cycle();
    end
    set_in('0, '0, '0, 1'b0);
  endtask

  task automatic test_reset_mid_packet();
    logic [N-1:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(4'b1000);
      set_in(4'b1000, (i == 0) ? 4'b1000 : 4'b0000, 4'b0000, 1'b0);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (out_sel !== e) begin n_fail++; $display("FAIL mid_sel[%0d]: got %b expected %b", i, out_sel, e); end
      next_cycle();
    end
    set_in('0, '0, '0, 1'b0);
    #1;
    n_tests++;
    if (locked !== 1'b1 || credits !== 3'd1) begin
      n_fail++;
      $display("FAIL mid_pre: got locked=%b credits=%0d expected locked=1 credits=1", locked, credits);
    end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    exp_q.push_back(4'b0001);
    set_in(4'b0011, 4'b0011, 4'b0011, 1'b0);
    #1;
    e = exp_q.pop_front();
    n_tests++;
    if (locked !== 1'b0 || credits !== 3'd4) begin
      n_fail++;
      $display("FAIL mid_post: got locked=%b credits=%0d expected locked=0 credits=4", locked, credits);
    end
    n_tests++;
    if (out_sel !== e) begin n_fail++; $display("FAIL mid_prio: got %b expected %b", out_sel, e); end
    next_cycle();
    set_in('0, '0, '0, 1'b0);
  endtask

  task automatic test_stall();
    logic es;
    do_reset();
    set_in(4'b0010, 4'b0010, 4'b0000, 1'b0);
    #1;
    n_tests++;
    if (out_sel !== 4'b0010) begin n_fail++; $display("FAIL stall_head: got %b expected 0010", out_sel); end
    next_cycle();
    for (int j = 1; j <= 12; j++) begin
      set_in('0, '0, '0, 1'b0);
      #1;
      es = STALL_ON && (j >= 9);
      n_tests++;
      if (stall_err !== es || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_wait[%0d]: got err=%b locked=%b expected err=%b locked=1", j, stall_err, locked, es);
      end
      next_cycle();
    end
    set_in(4'b0010, 4'b0000, 4'b0010, 1'b0);
    #1;
    n_tests++;
    if (out_sel !== 4'b0010 || stall_err !== STALL_ON) begin
      n_fail++;
      $display("FAIL stall_resume: got sel=%b err=%b expected sel=0010 err=%b", out_sel, stall_err, STALL_ON);
    end
    next_cycle();
    set_in('0, '0, '0, 1'b0);
    #1;
    n_tests++;
    if (stall_err !== STALL_ON || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hold: got err=%b locked=%b expected err=%b locked=0", stall_err, locked, STALL_ON);
    end
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    set_in('0, '0, '0, 1'b0);
    test_reset();
    test_round_robin();
    test_wormhole();
    test_credits();
    test_credit_simul();
    test_reset_mid_packet();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
